fp_add_operand_aligner: RTL and testbench
=========================================

Name: fp_add_operand_aligner

Overview:
- Two-stage pipelined operand-preparation stage for the FP32 adder. It sits directly downstream of the per-operand FP32 field decoder.
- Accepts two IEEE-754 single-precision operands over a valid/ready handshake.
- Classifies each operand (NaN/inf/zero-or-denormal), orders the pair by magnitude, and right-aligns the smaller significand to the larger exponent with guard/round/sticky bits.
- Feeds the adder core; denormals are flushed to zero.

Parameters:
- GRS_W, 3, extra low-order alignment bits appended below the 24-bit significand (minimum 3; LSB is always sticky).

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  stage can accept a pair this cycle
- op_a  input  32  FP32 operand A
- op_b  input  32  FP32 operand B
- out_valid  output  1  aligned result valid
- out_ready  input  1  consumer accepts result
- sign_big  output  1  sign of larger-magnitude operand
- sign_small  output  1  sign of smaller-magnitude operand
- eff_sub  output  1  sign_a XOR sign_b
- exp_big  output  8  biased exponent of larger operand (0 if both zero)
- mant_big  output  24+GRS_W  {hidden, frac, GRS_W zeros}
- mant_small  output  24+GRS_W  smaller significand shifted right by exponent difference, sticky ORed into LSB
- out_nan  output  1  result is NaN
- out_inf  output  1  result is infinity (not NaN)
- inf_sign  output  1  sign of infinite result

Behaviour:
- Decode per operand: s=op[31], e=op[30:23], f=op[22:0]. NaN = (e==FF & f!=0); inf = (e==FF & f==0); zero = (e==0).
- Flush to zero: an operand with e==0 uses e=0, significand 0, and keeps its sign.
- Significand for non-zero operands = {1,f}.
- Ordering: big = operand with larger {e,f}. On a tie, A is big.
- eff_sub = s_a ^ s_b, regardless of ordering.
- Stage 1 registers: decode, compare/swap, specials, diff = e_big - e_small (8-bit unsigned, always ≥0).
- Stage 2 registers: shift result.
- Shift: full = {sig_small, GRS_W zeros}, shifted right by diff.
  - Sticky = OR of all bits shifted out; it is ORed into the LSB.
  - If diff ≥ 24+GRS_W: mant_small = {0…0, (sig_small!=0)}.
  - If diff == 0: no shift and sticky is 0.
- Specials:
  - out_nan = NaN_a | NaN_b | (inf_a & inf_b & (s_a != s_b)).
  - out_inf = !out_nan & (inf_a | inf_b); inf_sign = sign of the infinite operand (equal signs when both are inf).
  - When out_nan or out_inf is 1, mant_big = mant_small = 0 and exp_big = FF.
  - When out_inf=1, sign_big = inf_sign; when out_nan=1, sign_big = 0.
- Handshake: valid bits v1 (stage 1) and v2 (stage 2 = out_valid).
  - adv2 = !v2 | out_ready.
  - adv1 = !v1 | adv2.
  - in_ready = adv1, combinational, with no dependence on in_valid.
  - Transfer in when in_valid & in_ready. Stage 1 loads when adv1. Stage 2 loads v1 contents when adv2.
  - Bubbles collapse: an empty stage never blocks.
- Latency: 2 cycles from accepted input to out_valid, with no stall. Throughput is 1 pair/cycle.
- Stall: while out_valid & !out_ready, all outputs hold stable. At most 2 pairs are in flight, and order is preserved.
- Simultaneous output pop and input push on a full pipe: both occur in the same cycle with no bubble.
- Reset: v1=v2=0, out_valid=0, and all data outputs 0. Reset mid-stall discards in-flight pairs. in_ready=1 in the first cycle after reset.
- Data registers load only on stage advance; holding data while invalid is allowed, but outputs are 0 after reset until the first load.

Test Plan:
- op_a=0x3F800000, op_b=0x3F000000, out_ready=1 -> 2 cycles later: exp_big=127, mant_big=0x4000000, mant_small=0x2000000, sign_big=0, eff_sub=0, nan=inf=0.
- op_a=0x3F000000, op_b=0xBF800000 -> swap: sign_big=1, sign_small=0, eff_sub=1, exp_big=127, mant_big=0x4000000, mant_small=0x2000000.
- Shift with sticky:
  - op_a=0x4B800000, op_b=0x3F800001 (diff 24) -> mant_small=0x0000005.
  - op_a=0x4F000000, op_b=0x3F800000 (diff 31) -> mant_small=0x0000001.
  - Equal operands 0x40400000 both -> A big, mant_small=mant_big=0x6000000.
- Specials:
  - 0x7F800000 + 0xFF800000 -> out_nan=1.
  - 0x7FC00000 + 0x3F800000 -> out_nan=1.
  - 0xFF800000 + 0x3F800000 -> out_inf=1, inf_sign=1, mants 0.
  - 0x00000001 + 0x3F800000 -> FTZ: big=B, mant_small=0.
- Backpressure: out_ready=0, 3 back-to-back valid inputs -> first two accepted, in_ready=0 on the third, outputs stable. Raise out_ready -> results emerge in order, one per cycle, with the third accepted the same cycle as the first pop.
- Assert rst for 1 cycle while stalled with 2 pairs in flight -> next cycle out_valid=0, in_ready=1, outputs 0. The pairs never appear.

Source files
------------

// File: rtl/fp_add_operand_aligner.sv
// Two-stage FP32 adder front end: classify both operands, order them by magnitude,
// and right-align the smaller significand with guard/round/sticky bits.
module fp_add_operand_aligner #(
    parameter int GRS_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       op_a,
    input  logic [31:0]       op_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              sign_big,
    output logic              sign_small,
    output logic              eff_sub,
    output logic [7:0]        exp_big,
    output logic [24+GRS_W-1:0] mant_big,
    output logic [24+GRS_W-1:0] mant_small,
    output logic              out_nan,
    output logic              out_inf,
    output logic              inf_sign
);
    localparam int W = 24 + GRS_W;

    logic        v1;
    logic        adv1, adv2;

    logic        s_a, s_b;
    logic [7:0]  e_a, e_b;
    logic [22:0] f_a, f_b;
    logic [23:0] sig_a, sig_b;
    logic        nan_a, nan_b, inf_a, inf_b;
    logic        a_big;
    logic        nan_in, inf_in;

    logic        s1_sign_big, s1_sign_small, s1_eff_sub;
    logic [7:0]  s1_exp_big, s1_diff;
    logic [23:0] s1_sig_big, s1_sig_small;
    logic        s1_nan, s1_inf, s1_inf_sign;

    logic [W-1:0] full, shifted, mask, aligned;
    logic         sticky;

    assign adv2     = !out_valid || out_ready;
    assign adv1     = !v1 || adv2;
    assign in_ready = adv1;

    // Denormals are flushed: exponent 0 forces the significand (and fraction) to 0.
    assign s_a   = op_a[31];
    assign s_b   = op_b[31];
    assign e_a   = op_a[30:23];
    assign e_b   = op_b[30:23];
    assign f_a   = (e_a == 8'd0) ? 23'd0 : op_a[22:0];
    assign f_b   = (e_b == 8'd0) ? 23'd0 : op_b[22:0];
    assign sig_a = (e_a == 8'd0) ? 24'd0 : {1'b1, f_a};
    assign sig_b = (e_b == 8'd0) ? 24'd0 : {1'b1, f_b};

    assign nan_a  = (&e_a) && (|f_a);
    assign nan_b  = (&e_b) && (|f_b);
    assign inf_a  = (&e_a) && !(|f_a);
    assign inf_b  = (&e_b) && !(|f_b);
    assign nan_in = nan_a || nan_b || (inf_a && inf_b && (s_a != s_b));
    assign inf_in = !nan_in && (inf_a || inf_b);

    assign a_big = {e_a, f_a} >= {e_b, f_b};

    always_ff @(posedge clk) begin
        if (rst) begin
            v1            <= 1'b0;
            s1_sign_big   <= 1'b0;
            s1_sign_small <= 1'b0;
            s1_eff_sub    <= 1'b0;
            s1_exp_big    <= 8'd0;
            s1_diff       <= 8'd0;
            s1_sig_big    <= 24'd0;
            s1_sig_small  <= 24'd0;
            s1_nan        <= 1'b0;
            s1_inf        <= 1'b0;
            s1_inf_sign   <= 1'b0;
        end else if (adv1) begin
            v1 <= in_valid;
            if (in_valid) begin
                s1_sign_big   <= a_big ? s_a : s_b;
                s1_sign_small <= a_big ? s_b : s_a;
                s1_eff_sub    <= s_a ^ s_b;
                s1_exp_big    <= a_big ? e_a : e_b;
                s1_diff       <= a_big ? (e_a - e_b) : (e_b - e_a);
                s1_sig_big    <= a_big ? sig_a : sig_b;
                s1_sig_small  <= a_big ? sig_b : sig_a;
                s1_nan        <= nan_in;
                s1_inf        <= inf_in;
                s1_inf_sign   <= inf_in && (inf_a ? s_a : s_b);
            end
        end
    end

    // Shifts of W or more leave only the sticky bit, set if anything was nonzero.
    always_comb begin
        full    = {s1_sig_small, {GRS_W{1'b0}}};
        shifted = '0;
        mask    = '0;
        sticky  = 1'b0;
        aligned = '0;
        if (int'(s1_diff) >= W) begin
            aligned = {{(W-1){1'b0}}, (s1_sig_small != 24'd0)};
        end else begin
            shifted = full >> s1_diff;
            mask    = (W'(1) << s1_diff) - W'(1);
            sticky  = |(full & mask);
            aligned = shifted | {{(W-1){1'b0}}, sticky};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            sign_big   <= 1'b0;
            sign_small <= 1'b0;
            eff_sub    <= 1'b0;
            exp_big    <= 8'd0;
            mant_big   <= '0;
            mant_small <= '0;
            out_nan    <= 1'b0;
            out_inf    <= 1'b0;
            inf_sign   <= 1'b0;
        end else if (adv2) begin
            out_valid <= v1;
            if (v1) begin
                sign_small <= s1_sign_small;
                eff_sub    <= s1_eff_sub;
                out_nan    <= s1_nan;
                out_inf    <= s1_inf;
                inf_sign   <= s1_inf_sign;
                if (s1_nan || s1_inf) begin
                    sign_big   <= s1_inf ? s1_inf_sign : 1'b0;
                    exp_big    <= 8'hFF;
                    mant_big   <= '0;
                    mant_small <= '0;
                end else begin
                    sign_big   <= s1_sign_big;
                    exp_big    <= s1_exp_big;
                    mant_big   <= {s1_sig_big, {GRS_W{1'b0}}};
                    mant_small <= aligned;
                end
            end
        end
    end
endmodule

// File: tb/tb_fp_add_operand_aligner.sv
// Directed-vector bench for fp_add_operand_aligner: single pairs, backpressure, reset mid-stall.
module tb_fp_add_operand_aligner;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] op_a, op_b;
    logic        out_valid;
    logic        out_ready;
    logic        sign_big, sign_small, eff_sub;
    logic [7:0]  exp_big;
    logic [26:0] mant_big, mant_small;
    logic        out_nan, out_inf, inf_sign;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] a, b;
        logic        sb, ss, es;
        logic [7:0]  e;
        logic [26:0] mb, ms;
        logic        n, i, isg;
    } vec_t;

    vec_t vecs[10];

    fp_add_operand_aligner #(.GRS_W(3)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .sign_big(sign_big), .sign_small(sign_small), .eff_sub(eff_sub),
        .exp_big(exp_big), .mant_big(mant_big), .mant_small(mant_small),
        .out_nan(out_nan), .out_inf(out_inf), .inf_sign(inf_sign)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Present one pair for a single accepting edge, then drop in_valid.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        op_a     = a;
        op_b     = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic runVector(input int k);
        int cnt;
        applyStimulus(vecs[k].a, vecs[k].b);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!out_valid && cnt < 8);
        if (!out_valid) begin
            checkOutput($sformatf("v%0d_timeout", k), 32'd0, 32'd1);
        end else begin
            checkOutput($sformatf("v%0d_latency", k), cnt, 2);
            checkOutput($sformatf("v%0d_sign_big", k), sign_big, vecs[k].sb);
            checkOutput($sformatf("v%0d_sign_small", k), sign_small, vecs[k].ss);
            checkOutput($sformatf("v%0d_eff_sub", k), eff_sub, vecs[k].es);
            checkOutput($sformatf("v%0d_exp_big", k), exp_big, vecs[k].e);
            checkOutput($sformatf("v%0d_mant_big", k), mant_big, vecs[k].mb);
            checkOutput($sformatf("v%0d_mant_small", k), mant_small, vecs[k].ms);
            checkOutput($sformatf("v%0d_nan", k), out_nan, vecs[k].n);
            checkOutput($sformatf("v%0d_inf", k), out_inf, vecs[k].i);
            if (vecs[k].i)
                checkOutput($sformatf("v%0d_inf_sign", k), inf_sign, vecs[k].isg);
        end
    endtask

    initial begin
        bit seen;
        vecs[0] = '{32'h3F800000, 32'h3F000000, 0, 0, 0, 8'd127, 27'h4000000, 27'h2000000, 0, 0, 0};
        vecs[1] = '{32'h3F000000, 32'hBF800000, 1, 0, 1, 8'd127, 27'h4000000, 27'h2000000, 0, 0, 0};
        vecs[2] = '{32'h4B800000, 32'h3F800001, 0, 0, 0, 8'd151, 27'h4000000, 27'h0000005, 0, 0, 0};
        vecs[3] = '{32'h4F000000, 32'h3F800000, 0, 0, 0, 8'd158, 27'h4000000, 27'h0000001, 0, 0, 0};
        vecs[4] = '{32'h40400000, 32'h40400000, 0, 0, 0, 8'd128, 27'h6000000, 27'h6000000, 0, 0, 0};
        vecs[5] = '{32'h7F800000, 32'hFF800000, 0, 1, 1, 8'hFF, 27'h0, 27'h0, 1, 0, 0};
        vecs[6] = '{32'h7FC00000, 32'h3F800000, 0, 0, 0, 8'hFF, 27'h0, 27'h0, 1, 0, 0};
        vecs[7] = '{32'hFF800000, 32'h3F800000, 1, 0, 1, 8'hFF, 27'h0, 27'h0, 0, 1, 1};
        vecs[8] = '{32'h00000001, 32'h3F800000, 0, 0, 0, 8'd127, 27'h4000000, 27'h0, 0, 0, 0};
        vecs[9] = '{32'h3FC00000, 32'h3F400000, 0, 0, 0, 8'd127, 27'h6000000, 27'h3000000, 0, 0, 0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        op_a      = 32'd0;
        op_b      = 32'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_in_ready", in_ready, 1);
        checkOutput("rst_exp_big", exp_big, 0);
        checkOutput("rst_mant_big", mant_big, 0);
        checkOutput("rst_mant_small", mant_small, 0);

        for (int k = 0; k < 10; k++) runVector(k);

        // Backpressure: fill both stages, third pair must wait until the first pop.
        @(negedge clk);
        out_ready = 1'b0;
        op_a = vecs[0].a; op_b = vecs[0].b; in_valid = 1'b1;
        @(negedge clk);
        checkOutput("bp_accept2_ready", in_ready, 1);
        op_a = vecs[2].a; op_b = vecs[2].b;
        @(negedge clk);
        op_a = vecs[3].a; op_b = vecs[3].b;
        checkOutput("bp_full_ready", in_ready, 0);
        checkOutput("bp_full_valid", out_valid, 1);
        checkOutput("bp_first_ms", mant_small, vecs[0].ms);
        repeat (2) @(negedge clk);
        checkOutput("bp_hold_ready", in_ready, 0);
        checkOutput("bp_hold_ms", mant_small, vecs[0].ms);
        checkOutput("bp_hold_exp", exp_big, vecs[0].e);
        out_ready = 1'b1;
        #1 checkOutput("bp_release_ready", in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        checkOutput("bp_second_valid", out_valid, 1);
        checkOutput("bp_second_ms", mant_small, vecs[2].ms);
        checkOutput("bp_second_exp", exp_big, vecs[2].e);
        @(negedge clk);
        checkOutput("bp_third_valid", out_valid, 1);
        checkOutput("bp_third_ms", mant_small, vecs[3].ms);
        checkOutput("bp_third_exp", exp_big, vecs[3].e);
        @(negedge clk);
        checkOutput("bp_drained", out_valid, 0);

        // Reset while stalled with two pairs in flight discards both.
        out_ready = 1'b0;
        op_a = vecs[9].a; op_b = vecs[9].b; in_valid = 1'b1;
        @(negedge clk);
        op_a = vecs[4].a; op_b = vecs[4].b;
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("rs_stalled_ready", in_ready, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rs_out_valid", out_valid, 0);
        checkOutput("rs_in_ready", in_ready, 1);
        checkOutput("rs_exp_big", exp_big, 0);
        checkOutput("rs_mant_big", mant_big, 0);
        checkOutput("rs_mant_small", mant_small, 0);
        out_ready = 1'b1;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        checkOutput("rs_no_ghost", seen, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
